// File: rtl/md_unit.sv
// md_unit: MIPS E-stage multiply/divide unit that owns HI/LO and raises the D-stage stall.
// Optional MADD/MADDU accumulate path is built only when MD_MADD_EN is defined.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        xstall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic [31:0] hi_r;
    logic [31:0] hi_s;
    logic [31:0] lo_r;
    logic [31:0] lo_s;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_hi_s;
    logic [31:0] pend_lo_r;
    logic [31:0] pend_lo_s;
    logic        pend_wr_r;
    logic        pend_wr_s;
    logic        op_signed_s;
    logic [63:0] prod_s;
    logic [63:0] div_s;
`ifdef MD_MADD_EN
    logic [63:0] acc_s;
`endif

    // Low 64 bits of the product of the extended operands equal the signed or unsigned product.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    // Sign-magnitude divide returning {remainder, quotient}; a zero divisor is masked
    // so the datapath never produces X, and the result is then discarded at commit.
    function automatic logic [63:0] divmod(input logic [31:0] n, input logic [31:0] d,
                                           input logic sgn);
        logic        n_neg;
        logic        d_neg;
        logic [31:0] n_mag;
        logic [31:0] d_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] q;
        logic [31:0] r;
        n_neg = sgn & n[31];
        d_neg = sgn & d[31];
        n_mag = n_neg ? (32'd0 - n) : n;
        if (d == 32'd0) begin
            d_mag = 32'd1;
        end else begin
            d_mag = d_neg ? (32'd0 - d) : d;
        end
        q_mag = n_mag / d_mag;
        r_mag = n_mag % d_mag;
        q = (n_neg ^ d_neg) ? (32'd0 - q_mag) : q_mag;
        r = n_neg ? (32'd0 - r_mag) : r_mag;
        return {r, q};
    endfunction

    // Operand datapath: even op codes are the signed variants.
    always_comb begin
        op_signed_s = ~md_op[0];
        prod_s      = mul64(a, b, op_signed_s);
        div_s       = divmod(a, b, op_signed_s);
`ifdef MD_MADD_EN
        acc_s       = {hi_r, lo_r} + prod_s;
`endif
    end

    // Next-state logic: launch at start, count down while busy, commit on the final edge.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        pend_hi_s = pend_hi_r;
        pend_lo_s = pend_lo_r;
        pend_wr_s = pend_wr_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            state_s   = ST_BUSY;
                            cnt_s     = MULT_N;
                            pend_hi_s = prod_s[63:32];
                            pend_lo_s = prod_s[31:0];
                            pend_wr_s = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_s   = ST_BUSY;
                            cnt_s     = DIV_N;
                            pend_hi_s = div_s[63:32];
                            pend_lo_s = div_s[31:0];
                            pend_wr_s = (b != 32'd0);
                        end
                        OP_MTHI: begin
                            hi_s = a;
                        end
                        OP_MTLO: begin
                            lo_s = a;
                        end
`ifdef MD_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            state_s   = ST_BUSY;
                            cnt_s     = MULT_N;
                            pend_hi_s = acc_s[63:32];
                            pend_lo_s = acc_s[31:0];
                            pend_wr_s = 1'b1;
                        end
`endif
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_s = cnt_r - 8'd1;
                if (cnt_r <= 8'd1) begin
                    state_s   = ST_IDLE;
                    cnt_s     = 8'd0;
                    pend_wr_s = 1'b0;
                    if (pend_wr_r) begin
                        hi_s = pend_hi_r;
                        lo_s = pend_lo_r;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = 8'd0;
                pend_wr_s = 1'b0;
            end
        endcase
    end

    // State register; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
            pend_wr_r <= pend_wr_s;
        end
    end

    // The stall must be combinational so D sees it in the start cycle itself.
    assign busy   = (state_r == ST_BUSY);
    assign xstall = md_use_d & (start | busy);
    assign hi     = hi_r;
    assign lo     = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit; commits are checked by a monitor on busy falling.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        xstall;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .xstall   (xstall),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: measures each busy window and checks hi/lo the cycle busy drops.
    initial begin : monitor
        logic prev_busy;
        int   len;
        exp_t e;
        prev_busy = 1'b0;
        len       = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                len       = prev_busy ? len + 1 : 1;
                prev_busy = 1'b1;
            end else begin
                if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: busy window of %0d cycles, expected none", len);
                    end else begin
                        e = sb_q.pop_front();
                        check("commit_hi", hi, e.hi);
                        check("commit_lo", lo, e.lo);
                        check("busy_len", 32'(len), 32'(e.len));
                    end
                end
                prev_busy = 1'b0;
            end
        end
    end

    // Multi-cycle op: stall and HI/LO hold are checked every cycle, the commit by the monitor.
    task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input logic use_d, input int n,
                          input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.len = n;
        sb_q.push_back(e);
        start    = 1'b1;
        md_op    = op;
        a        = va;
        b        = vb;
        md_use_d = use_d;
        @(negedge clk);
        check("xstall_start", {31'd0, xstall}, {31'd0, use_d});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("xstall_busy", {31'd0, xstall}, {31'd0, use_d});
            check("hold_hi", hi, m_hi);
            check("hold_lo", lo, m_lo);
        end
        @(negedge clk);
        check("xstall_after", {31'd0, xstall}, 32'd0);
        m_hi     = ehi;
        m_lo     = elo;
        md_use_d = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Single-cycle MTHI/MTLO.
    task automatic move_to(input logic [2:0] op, input logic [31:0] va, input logic use_d);
        start    = 1'b1;
        md_op    = op;
        a        = va;
        b        = $urandom;
        md_use_d = use_d;
        @(negedge clk);
        check("xstall_mt", {31'd0, xstall}, {31'd0, use_d});
        @(posedge clk);
        #1;
        start    = 1'b0;
        md_use_d = 1'b0;
        if (op == 3'b100) m_hi = va;
        else              m_lo = va;
        @(negedge clk);
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset    = 1'b1;
        start    = 1'b1;
        md_op    = 3'b000;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        md_use_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_xstall", {31'd0, xstall}, 32'd0);
        @(posedge clk);
        #1;

        run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(3'b011, 32'd7, 32'd2, 1'b0, 10, 32'd1, 32'd3);
        move_to(3'b100, 32'h0000_0011, 1'b1);
        move_to(3'b101, 32'h0000_0022, 1'b0);
        run_op(3'b011, 32'd5, 32'd0, 1'b1, 10, 32'h0000_0011, 32'h0000_0022);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0, 32'h8000_0000);

`ifdef MD_MADD_EN
        move_to(3'b100, 32'd0, 1'b0);
        move_to(3'b101, 32'd10, 1'b0);
        run_op(3'b111, 32'd4, 32'd5, 1'b1, 5, 32'd0, 32'd30);
`else
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            md_op = (k == 0) ? 3'b110 : 3'b111;
            a     = 32'd4;
            b     = 32'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check("madd_noop_busy", {31'd0, busy}, 32'd0);
                check("madd_noop_hi", hi, m_hi);
                check("madd_noop_lo", lo, m_lo);
            end
            @(posedge clk);
            #1;
        end
`endif

        // Reset during the fourth busy cycle of a divide.
        begin
            exp_t e;
            e.hi = 32'd0;
            e.lo = 32'd0;
            e.len = 4;
            sb_q.push_back(e);
        end
        start = 1'b1;
        md_op = 3'b010;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        repeat (12) begin
            @(negedge clk);
            check("no_late_busy", {31'd0, busy}, 32'd0);
            check("no_late_hi", hi, m_hi);
            check("no_late_lo", lo, m_lo);
        end

        repeat (2) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
